// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern output stage.
package led_pattern_pkg;

  // Host command mode field
  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_SOLID   = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  // Controller state
  typedef enum logic [1:0] {
    StStatic   = 2'd0,
    StBlinkOn  = 2'd1,
    StBlinkOff = 2'd2
  } state_e;

  // Bit positions inside the colour enable field
  localparam int unsigned COLOUR_RED   = 0;
  localparam int unsigned COLOUR_GREEN = 1;
  localparam logic [1:0]  COLOUR_BOTH  = 2'b11;

endpackage

// File: rtl/led_tick_prescaler.sv
// Down counter producing one terminal-count pulse every TICK_DIV enabled clocks.
module led_tick_prescaler #(
  parameter int unsigned TICK_DIV = 3325000,
  parameter int unsigned Width    = $clog2(TICK_DIV)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] Reload = Width'(TICK_DIV - 1);

  logic [Width-1:0] cnt_q;

  // Reload on reset/load and on wrap; count only while enabled
  always_ff @(posedge Clk) begin
    if (Rst || load_i) begin
      cnt_q <= Reload;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_q <= Reload;
      end else begin
        cnt_q <= cnt_q - Width'(1);
      end
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED output stage: selects off / breathe pass-through / solid / blink per host command
// and drives the active-low red/green pins from a register.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int unsigned TICK_DIV = 3325000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [1:0]       cmd_colour,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             flash_red_n,
  input  logic             flash_green_n,
  output logic             red,
  output logic             green,
  output logic             busy
);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [1:0]       colour_q;
  logic [CNT_W-1:0] count_q;
  logic             red_q;
  logic             green_q;

  logic       accept;
  logic       blink_load;
  logic       blink_en;
  logic       tick;
  logic [1:0] led_on;

  // A finite blink (non-zero count) locks out new commands until it completes
  assign busy       = (state_q != StStatic) && (count_q != '0);
  assign cmd_ready  = !busy;
  assign accept     = cmd_valid && cmd_ready;
  assign blink_load = accept && (cmd_mode == MODE_BLINK);
  assign blink_en   = (state_q != StStatic);

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clk    (Clk),
    .Rst    (Rst),
    .load_i (blink_load),
    .en_i   (blink_en),
    .tc_o   (tick)
  );

  // Per-colour LED-on decision from the current state and mode
  always_comb begin
    led_on = '0;
    unique case (state_q)
      StStatic: begin
        case (mode_q)
          MODE_BREATHE: led_on = ~{flash_green_n, flash_red_n} & colour_q;
          MODE_SOLID:   led_on = colour_q;
          default:      led_on = '0;
        endcase
      end
      StBlinkOn: led_on = colour_q;
      default:   led_on = '0;
    endcase
  end

  // Command acceptance, blink sequencing and registered LED drive
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StStatic;
      mode_q   <= MODE_BREATHE;
      colour_q <= COLOUR_BOTH;
      count_q  <= '0;
      red_q    <= 1'b1;
      green_q  <= 1'b1;
    end else begin
      red_q   <= !led_on[COLOUR_RED];
      green_q <= !led_on[COLOUR_GREEN];
      if (accept) begin
        mode_q   <= cmd_mode;
        colour_q <= cmd_colour;
        count_q  <= cmd_count;
        state_q  <= (cmd_mode == MODE_BLINK) ? StBlinkOn : StStatic;
      end else if (tick) begin
        unique case (state_q)
          StBlinkOn: state_q <= StBlinkOff;
          StBlinkOff: begin
            if (count_q == CNT_W'(1)) begin
              // Last blink done: fall back to breathing on both colours
              state_q  <= StStatic;
              mode_q   <= MODE_BREATHE;
              colour_q <= COLOUR_BOTH;
              count_q  <= '0;
            end else begin
              state_q <= StBlinkOn;
              // Zero count means endless, so it must never wrap
              if (count_q != '0) begin
                count_q <= count_q - CNT_W'(1);
              end
            end
          end
          default: state_q <= StStatic;
        endcase
      end
    end
  end

  assign red   = red_q;
  assign green = green_q;

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Output stage between the breathing LED flasher and the red/green LED pins. Accepts host commands over a valid/ready handshake that select the LED mode: off, pass-through of the flasher's breathing pattern, solid colour, or a counted or endless blink. Runs on the flasher's oscillator clock (`xclk`). Drives the final active-low LED outputs.

## Interface

Parameters:
- `TICK_DIV`, 3325000: clock cycles per blink half-period (≈125 ms at 26.6 MHz); must be ≥ 2.
- `CNT_W`, 8: width of the blink-count field.

Ports:
- `Clk`  in  1  LED domain clock, driven from flasher `xclk`.
- `Rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_mode`  in  2  mode: 0 OFF, 1 BREATHE, 2 SOLID, 3 BLINK.
- `cmd_colour`  in  2  colour enables: bit0 red, bit1 green.
- `cmd_count`  in  CNT_W  blink count; 0 means blink forever.
- `flash_red_n`  in  1  flasher red output, active-low, `Clk` domain.
- `flash_green_n`  in  1  flasher green output, active-low, `Clk` domain.
- `red`  out  1  LED red drive, active-low, registered.
- `green`  out  1  LED green drive, active-low, registered.
- `busy`  out  1  finite blink in progress.

## Operation

- Accept rule: a command is accepted on an edge where `cmd_valid & cmd_ready` is true. On that edge `mode_q`, `colour_q` and `count_q` load from the command.
- States:
  - STATIC: holds OFF, BREATHE or SOLID.
  - BLINK_ON
  - BLINK_OFF
- Per-colour LED-on condition (colour enabled by `colour_q`), by state:
  - OFF: never on.
  - BREATHE: on when the matching `flash_*_n` = 0.
  - SOLID: always on.
  - BLINK_ON: always on.
  - BLINK_OFF: never on.
  - A disabled colour is always off.
- Output: `red`/`green` = NOT(on), registered each clock.
- BLINK command:
  - Acceptance enters BLINK_ON and loads the prescaler with `TICK_DIV-1`.
  - When the prescaler reaches 0 it reloads and the state toggles ON↔OFF.
  - Each transition from BLINK_OFF to BLINK_ON completes one blink.
  - Finite blink (count N > 0): at the end of the Nth BLINK_OFF the block goes to STATIC with mode BREATHE and colour 3.
  - Endless blink (count 0): never terminates by itself.
- `cmd_ready` = 0 only during a finite blink. It is 1 in STATIC and during an endless blink, so a new command preempts an endless blink immediately.
- `busy` = 1 from the acceptance edge of a finite blink until the return-to-BREATHE edge.
- Commands presented while `cmd_ready` = 0 are not consumed. The sender holds them.
- A SOLID or BREATHE command with colour 0 behaves as OFF.
- A BLINK command with colour 0 runs the full blink timing, including `busy`, with both LEDs off.

## Timing

- Reset values (one edge with `Rst` = 1):
  - STATIC, mode BREATHE, colour 3, prescaler = `TICK_DIV-1`.
  - `red` = 1, `green` = 1, `cmd_ready` = 1, `busy` = 0.
- Reset mid-blink: aborts on the same edge and produces the reset values above. `Rst` has priority over an accept on the same edge.
- BREATHE pass-through latency: `flash_*_n` at edge E appears on the output after edge E+1 (one register stage).
- Command latency: for a command accepted at edge E, outputs reflect the new mode after edge E+1.
- BLINK_ON and BLINK_OFF each last exactly `TICK_DIV` clocks. A full blink period is 2·`TICK_DIV` clocks.
- Finite blink of N:
  - `busy` is high for exactly 2·N·`TICK_DIV` clocks.
  - `cmd_ready` rises on the same edge `busy` falls.
  - A command pending at that moment is accepted on the following edge.
- Blink counter: decrements at each OFF→ON transition and at the final OFF end. Width is `CNT_W`, with no wrap. The terminal test is count_q == 1 at the OFF end.

## Structure

- Package `led_pattern_pkg`:
  - Mode encodings `MODE_OFF`, `MODE_BREATHE`, `MODE_SOLID`, `MODE_BLINK`.
  - State encoding for STATIC, BLINK_ON and BLINK_OFF.
  - Colour bit indices.
- Sub-module `led_tick_prescaler`:
  - Synchronous down counter with load, enable and terminal-count pulse.
  - Width `$clog2(TICK_DIV)`.
  - Loaded on blink accept and on reset; free-runs only in the blink states.

## Test plan

All scenarios use `TICK_DIV` = 4 and `CNT_W` = 8.

1. Reset, then toggle `flash_red_n` 0/1 each clock → `red` follows with 1-cycle latency, `green` follows `flash_green_n`. Before the first edge after reset, `red` = `green` = 1 and `cmd_ready` = 1.
2. SOLID, colour 1 → `red` = 0 from accept+1 onward, `green` = 1, `cmd_ready` stays 1.
3. BLINK, colour 2, count 3 →
   - `green` low for 4 clocks, high for 4 clocks, repeated 3 times.
   - `busy` high for 24 clocks, `cmd_ready` low for the same window.
   - Then back to BREATHE pass-through on both colours.
4. BLINK, count 0, colour 3; then after 10 clocks, OFF → the OFF command is accepted immediately and both outputs are 1 from accept+1.
5. During a finite blink (count 2), hold `cmd_valid` with SOLID → not accepted until `busy` falls, then accepted on the next edge.
6. Assert `Rst` for 1 clock in the middle of BLINK_ON with count 5 → next cycle shows the reset values; BREATHE pass-through resumes.
